acc_multi_eng_ctrl: RTL and testbench
=====================================

ACC_MULTI_ENG_CTRL -- requirements
Module: acc_multi_eng_ctrl

Interface
REQ-001 SHALL have parameter NUM_ENG, default 4, number of conv engines managed (1..16).
REQ-002 SHALL have parameter ENG_W, default max(1,clog2(NUM_ENG)), engine-index width.
REQ-003 SHALL have parameter CNT_W, default 32, retired-job counter width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ap_start  input  1  kernel start request (ap_ctrl_chain).
REQ-007 SHALL have port ap_continue  input  1  host acknowledge of ap_done.
REQ-008 SHALL have port ap_ready  output  1  start accepted this cycle when high with ap_start.
REQ-009 SHALL have port ap_done  output  1  registered; oldest outstanding job finished.
REQ-010 SHALL have port ap_idle  output  1  no job in flight and no done pending.
REQ-011 SHALL have port op_start  output  NUM_ENG  registered one-cycle start pulse per engine.
REQ-012 SHALL have port end_conv  input  NUM_ENG  per-engine convolution-finished pulse.
REQ-013 SHALL have port wmst_done  input  NUM_ENG  per-engine AXI write-master finished pulse.
REQ-014 SHALL have port done_eng  output  ENG_W  index of engine reported by current ap_done.
REQ-015 SHALL have port job_cnt  output  CNT_W  count of retired jobs.

Function
REQ-016 Each engine SHALL track state IDLE, RUN, FIN.
REQ-017 ap_ready SHALL be combinational: high iff any engine IDLE.
REQ-018 On ap_start&&ap_ready at edge t, chosen engine k SHALL go RUN and op_start[k] SHALL be high for exactly cycle t+1; all other op_start bits low.
REQ-019 k SHALL be first IDLE engine searching upward from round-robin pointer rr, wrapping; rr SHALL become (k+1) mod NUM_ENG.
REQ-020 In RUN, end_conv[k] and wmst_done[k] SHALL be latched independently; engine SHALL go FIN at the edge both are seen, in either order or same cycle.
REQ-021 end_conv/wmst_done on an IDLE or FIN engine SHALL be ignored.
REQ-022 Dispatched indices SHALL be pushed into an in-order ID FIFO of depth NUM_ENG; jobs SHALL retire strictly in dispatch order.
REQ-023 ap_done SHALL set at the edge where FIFO non-empty, head engine FIN and ap_done low; done_eng SHALL equal head index while ap_done high.
REQ-024 ap_done&&ap_continue SHALL at the same edge clear ap_done, pop FIFO, return head engine to IDLE, increment job_cnt (wrap at 2^CNT_W).
REQ-025 ap_done SHALL stay low at least one cycle between consecutive jobs.
REQ-026 ap_continue with ap_done low SHALL have no effect.
REQ-027 Dispatch and retirement in the same cycle SHALL both occur (simultaneous push/pop); a retired engine SHALL become dispatchable the following cycle, not the same cycle.
REQ-028 ap_idle SHALL be combinational: high iff all engines IDLE and ap_done low.
REQ-029 FIFO overflow SHALL be impossible by construction (dispatch requires an IDLE engine).

Reset
REQ-030 rst_n low SHALL asynchronously force all engines IDLE, latches clear, FIFO empty, rr=0, ap_done=0, op_start=0, done_eng=0, job_cnt=0; hence ap_ready=1, ap_idle=1.
REQ-031 Reset mid-operation SHALL discard all in-flight jobs; no ap_done or op_start after release until a new ap_start.

Structure
REQ-032 Package acc_ctrl_pkg SHALL hold engine-state encoding (IDLE/RUN/FIN) and clog2 helper.
REQ-033 The ID FIFO SHALL be sub-module acc_id_fifo (width ENG_W, depth NUM_ENG, push/pop/empty/head, same-cycle push+pop).

Verification
REQ-034 NUM_ENG=4, one ap_start pulse -> op_start=4'b0001 for one cycle; end_conv[0] then wmst_done[0] 5 cycles later -> ap_done next edge, done_eng=0; ap_continue -> ap_done low, job_cnt=1, ap_idle=1.
REQ-035 ap_start held 6 cycles -> op_start 0001,0010,0100,1000 on successive cycles, then ap_ready=0 and no further pulses.
REQ-036 Jobs on engines 0,1; engine 1 finishes first -> no ap_done until engine 0 FIN; then done_eng=0, after continue done_eng=1 after one low cycle.
REQ-037 end_conv[2] and wmst_done[2] same cycle -> FIN; wmst_done[3] while engine 3 IDLE -> ignored, ap_idle stays 1.
REQ-038 All 4 busy, ap_done high, ap_start and ap_continue same cycle -> retire engine 0, no dispatch that cycle; dispatch to engine 0 next cycle.
REQ-039 rst_n low while 3 jobs RUN and ap_done high -> all outputs at reset values immediately; later wmst_done/end_conv pulses produce no ap_done.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// Shared types and helpers for the multi-engine accelerator controller.
// Engine state encoding and a constant-foldable clog2.
package acc_ctrl_pkg;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_RUN  = 2'd1,
        ENG_FIN  = 2'd2
    } eng_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/acc_id_fifo.sv
// In-order engine-ID FIFO; head is the oldest dispatched engine.
// Supports push and pop in the same cycle.
module acc_id_fifo
    import acc_ctrl_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/acc_multi_eng_ctrl.sv
// ap_ctrl_chain front end dispatching jobs round-robin to conv engines.
// Jobs retire strictly in dispatch order through an ID FIFO.
module acc_multi_eng_ctrl
    import acc_ctrl_pkg::*;
#(
    parameter int NUM_ENG = 4,
    parameter int ENG_W   = (clog2(NUM_ENG) < 1) ? 1 : clog2(NUM_ENG),
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ap_start,
    input  logic               ap_continue,
    output logic               ap_ready,
    output logic               ap_done,
    output logic               ap_idle,
    output logic [NUM_ENG-1:0] op_start,
    input  logic [NUM_ENG-1:0] end_conv,
    input  logic [NUM_ENG-1:0] wmst_done,
    output logic [ENG_W-1:0]   done_eng,
    output logic [CNT_W-1:0]   job_cnt
);

    eng_state_e         eng_st [NUM_ENG];
    logic [NUM_ENG-1:0] ec_seen;
    logic [NUM_ENG-1:0] wd_seen;
    logic [ENG_W-1:0]   rr;
    logic [ENG_W-1:0]   pick;
    logic [ENG_W-1:0]   head;
    logic               any_idle;
    logic               all_idle;
    logic               found;
    logic               fifo_empty;
    logic               head_fin;
    logic               dispatch;
    logic               retire;
    logic               set_done;
    int                 scan_idx;

    // idle scan and round-robin pick of the next engine
    always_comb begin
        any_idle = 1'b0;
        all_idle = 1'b1;
        found    = 1'b0;
        pick     = '0;
        scan_idx = 0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (eng_st[i] == ENG_IDLE) any_idle = 1'b1;
            else all_idle = 1'b0;
        end
        for (int off = 0; off < NUM_ENG; off++) begin
            scan_idx = (int'(rr) + off) % NUM_ENG;
            if (!found && eng_st[scan_idx] == ENG_IDLE) begin
                found = 1'b1;
                pick  = ENG_W'(scan_idx);
            end
        end
    end

    // is the oldest outstanding job finished
    always_comb begin
        head_fin = 1'b0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (head == ENG_W'(i) && eng_st[i] == ENG_FIN) head_fin = 1'b1;
        end
        head_fin = head_fin && !fifo_empty;
    end

    assign dispatch = ap_start && any_idle;
    assign retire   = ap_done && ap_continue;
    assign set_done = !ap_done && head_fin;
    assign ap_ready = any_idle;
    assign ap_idle  = all_idle && !ap_done;

    acc_id_fifo #(
        .W     (ENG_W),
        .DEPTH (NUM_ENG)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (dispatch),
        .din   (pick),
        .pop   (retire),
        .empty (fifo_empty),
        .head  (head)
    );

    // per-engine IDLE/RUN/FIN tracking with independent done latches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENG; i++) eng_st[i] <= ENG_IDLE;
            ec_seen <= '0;
            wd_seen <= '0;
        end else begin
            for (int i = 0; i < NUM_ENG; i++) begin
                unique case (eng_st[i])
                    ENG_IDLE: begin
                        if (dispatch && pick == ENG_W'(i)) begin
                            eng_st[i]  <= ENG_RUN;
                            ec_seen[i] <= 1'b0;
                            wd_seen[i] <= 1'b0;
                        end
                    end
                    ENG_RUN: begin
                        if ((ec_seen[i] || end_conv[i]) &&
                            (wd_seen[i] || wmst_done[i])) begin
                            eng_st[i]  <= ENG_FIN;
                            ec_seen[i] <= 1'b0;
                            wd_seen[i] <= 1'b0;
                        end else begin
                            ec_seen[i] <= ec_seen[i] || end_conv[i];
                            wd_seen[i] <= wd_seen[i] || wmst_done[i];
                        end
                    end
                    ENG_FIN: begin
                        if (retire && head == ENG_W'(i)) eng_st[i] <= ENG_IDLE;
                    end
                    default: eng_st[i] <= ENG_IDLE;
                endcase
            end
        end
    end

    // start pulses, rr pointer, done handshake and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_start <= '0;
            rr       <= '0;
            ap_done  <= 1'b0;
            done_eng <= '0;
            job_cnt  <= '0;
        end else begin
            op_start <= dispatch ? (NUM_ENG'(1) << pick) : '0;
            if (dispatch) begin
                rr <= (pick == ENG_W'(NUM_ENG - 1)) ? '0 : pick + ENG_W'(1);
            end
            unique case (1'b1)
                retire: begin
                    ap_done <= 1'b0;
                    job_cnt <= job_cnt + 1'b1;
                end
                set_done: begin
                    ap_done  <= 1'b1;
                    done_eng <= head;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_multi_eng_ctrl.sv
// Self-checking bench for acc_multi_eng_ctrl with a queue-based job model.
// Directed scenarios plus a randomized run.
module tb_acc_multi_eng_ctrl;

    localparam int N  = 4;
    localparam int EW = 2;
    localparam int CW = 32;
    localparam logic [40:0] RST_VEC = {1'b1, 1'b0, 1'b1, 4'b0, 2'b0, 32'b0};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ap_start = 1'b0;
    logic          ap_continue = 1'b0;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_idle;
    logic [N-1:0]  op_start;
    logic [N-1:0]  end_conv = '0;
    logic [N-1:0]  wmst_done = '0;
    logic [EW-1:0] done_eng;
    logic [CW-1:0] job_cnt;
    logic [40:0]   obs;

    int checks = 0;
    int errors = 0;

    // model: 0 idle, 1 running, 2 finished
    int          m_st [N];
    bit          m_e [N];
    bit          m_w [N];
    int          m_q [$];
    int          m_rr;
    bit          m_done;
    int          m_deng;
    int unsigned m_cnt;
    logic [N-1:0] m_op;

    acc_multi_eng_ctrl #(
        .NUM_ENG (N),
        .ENG_W   (EW),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ap_start    (ap_start),
        .ap_continue (ap_continue),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .op_start    (op_start),
        .end_conv    (end_conv),
        .wmst_done   (wmst_done),
        .done_eng    (done_eng),
        .job_cnt     (job_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {ap_ready, ap_done, ap_idle, op_start, done_eng, job_cnt};

    function automatic logic [40:0] exp_vec();
        bit rdy;
        bit idl;
        rdy = 0;
        idl = !m_done;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 0) rdy = 1;
            else idl = 0;
        end
        return {rdy, m_done, idl, m_op, EW'(m_deng), CW'(m_cnt)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0;
            m_e[i]  = 0;
            m_w[i]  = 0;
        end
        m_q.delete();
        m_rr   = 0;
        m_done = 0;
        m_deng = 0;
        m_cnt  = 0;
        m_op   = '0;
    endtask

    task automatic model_next();
        bit rdy;
        bit disp;
        bit ret;
        bit setd;
        bit got;
        int k;
        int hd;
        rdy = 0;
        for (int i = 0; i < N; i++) if (m_st[i] == 0) rdy = 1;
        k = 0;
        got = 0;
        for (int off = 0; off < N; off++) begin
            if (!got && m_st[(m_rr + off) % N] == 0) begin
                k = (m_rr + off) % N;
                got = 1;
            end
        end
        disp = ap_start && rdy;
        ret  = m_done && ap_continue;
        hd   = (m_q.size() > 0) ? m_q[0] : 0;
        setd = !m_done && m_q.size() > 0 && m_st[hd] == 2;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 1) begin
                m_e[i] = m_e[i] | end_conv[i];
                m_w[i] = m_w[i] | wmst_done[i];
                if (m_e[i] && m_w[i]) begin
                    m_st[i] = 2;
                    m_e[i] = 0;
                    m_w[i] = 0;
                end
            end
        end
        if (ret) begin
            m_st[hd] = 0;
            void'(m_q.pop_front());
            m_cnt++;
            m_done = 0;
        end else if (setd) begin
            m_done = 1;
            m_deng = hd;
        end
        m_op = '0;
        if (disp) begin
            m_st[k] = 1;
            m_e[k] = 0;
            m_w[k] = 0;
            m_q.push_back(k);
            m_rr = (k + 1) % N;
            m_op[k] = 1'b1;
        end
    endtask

    task automatic cyc(input logic s, input logic c,
                       input logic [N-1:0] ec, input logic [N-1:0] wd);
        ap_start    = s;
        ap_continue = c;
        end_conv    = ec;
        wmst_done   = wd;
        model_next();
        @(posedge clk);
        #1;
        ap_start    = 1'b0;
        ap_continue = 1'b0;
        end_conv    = '0;
        wmst_done   = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        checks++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", obs, RST_VEC);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_single_job();
        logic [9:0] rows [11] = '{
            10'b10_0000_0000, 10'b0, 10'b00_0001_0000, 10'b0, 10'b0,
            10'b0, 10'b0, 10'b00_0000_0001, 10'b0, 10'b01_0000_0000,
            10'b0};
        do_reset();
        for (int r = 0; r < 11; r++) begin
            cyc(rows[r][9], rows[r][8], rows[r][7:4], rows[r][3:0]);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL single_model r%0d: got %h expected %h",
                         r, obs, exp_vec());
            end
            if (r == 0) begin
                checks++;
                if (op_start !== 4'b0001) begin
                    errors++;
                    $display("FAIL single_op_start: got %b expected 0001",
                             op_start);
                end
            end
            if (r == 8) begin
                checks++;
                if ({ap_done, done_eng} !== 3'b100) begin
                    errors++;
                    $display("FAIL single_done: got %b expected 100",
                             {ap_done, done_eng});
                end
            end
            if (r == 9) begin
                checks++;
                if ({ap_done, ap_idle, job_cnt} !== {1'b0, 1'b1, 32'd1}) begin
                    errors++;
                    $display("FAIL single_retire: got %b %b %0d expected 0 1 1",
                             ap_done, ap_idle, job_cnt);
                end
            end
        end
    endtask

    task automatic test_fill();
        logic [N-1:0] exp_op [6] = '{4'b0001, 4'b0010, 4'b0100,
                                     4'b1000, 4'b0000, 4'b0000};
        do_reset();
        for (int r = 0; r < 6; r++) begin
            cyc(1'b1, 1'b0, '0, '0);
            checks++;
            if (op_start !== exp_op[r] || obs !== exp_vec()) begin
                errors++;
                $display("FAIL fill r%0d: op_start %b expected %b, vec %h expected %h",
                         r, op_start, exp_op[r], obs, exp_vec());
            end
        end
        checks++;
        if (ap_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready: got %b expected 0", ap_ready);
        end
    endtask

    task automatic test_in_order();
        logic [9:0] rows [12] = '{
            10'b10_0000_0000, 10'b10_0000_0000, 10'b00_0010_0010, 10'b0,
            10'b0, 10'b0, 10'b00_0001_0000, 10'b00_0000_0001, 10'b0,
            10'b01_0000_0000, 10'b0, 10'b01_0000_0000};
        do_reset();
        for (int r = 0; r < 12; r++) begin
            cyc(rows[r][9], rows[r][8], rows[r][7:4], rows[r][3:0]);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL order_model r%0d: got %h expected %h",
                         r, obs, exp_vec());
            end
            if (r == 5 || r == 7 || r == 9) begin
                checks++;
                if (ap_done !== 1'b0) begin
                    errors++;
                    $display("FAIL order_wait r%0d: ap_done %b expected 0",
                             r, ap_done);
                end
            end
            if (r == 8 || r == 10) begin
                checks++;
                if ({ap_done, done_eng} !== {1'b1, EW'(r == 10)}) begin
                    errors++;
                    $display("FAIL order_done r%0d: got %b expected %b",
                             r, {ap_done, done_eng}, {1'b1, EW'(r == 10)});
                end
            end
        end
        checks++;
        if (job_cnt !== 32'd2 || ap_idle !== 1'b1) begin
            errors++;
            $display("FAIL order_end: job_cnt %0d idle %b expected 2 1",
                     job_cnt, ap_idle);
        end
    endtask

    task automatic test_same_cycle_ignore();
        logic [9:0] rows [17] = '{
            10'b00_1111_1111, 10'b00_0000_1000, 10'b10_0000_0000,
            10'b00_0001_0000, 10'b0, 10'b0, 10'b10_0000_0000,
            10'b10_0000_0000, 10'b00_0100_0100, 10'b00_0000_0001,
            10'b0, 10'b01_0000_0000, 10'b00_0010_0010, 10'b0,
            10'b01_0000_0000, 10'b0, 10'b01_0000_0000};
        do_reset();
        for (int r = 0; r < 17; r++) begin
            cyc(rows[r][9], rows[r][8], rows[r][7:4], rows[r][3:0]);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL same_model r%0d: got %h expected %h",
                         r, obs, exp_vec());
            end
            if (r < 2) begin
                checks++;
                if ({ap_idle, ap_done, op_start} !== 6'b100000) begin
                    errors++;
                    $display("FAIL ignore_idle r%0d: got %b expected 100000",
                             r, {ap_idle, ap_done, op_start});
                end
            end
            if (r == 5) begin
                checks++;
                if (ap_done !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_stale: ap_done %b expected 0", ap_done);
                end
            end
            if (r == 15) begin
                checks++;
                if ({ap_done, done_eng} !== 3'b110) begin
                    errors++;
                    $display("FAIL same_fin: got %b expected 110",
                             {ap_done, done_eng});
                end
            end
        end
        checks++;
        if (job_cnt !== 32'd3 || ap_idle !== 1'b1) begin
            errors++;
            $display("FAIL same_end: job_cnt %0d idle %b expected 3 1",
                     job_cnt, ap_idle);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] rows [9] = '{
            10'b10_0000_0000, 10'b10_0000_0000, 10'b10_0000_0000,
            10'b10_0000_0000, 10'b00_0001_0001, 10'b0,
            10'b11_0000_0000, 10'b10_0000_0000, 10'b0};
        do_reset();
        for (int r = 0; r < 9; r++) begin
            cyc(rows[r][9], rows[r][8], rows[r][7:4], rows[r][3:0]);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_model r%0d: got %h expected %h",
                         r, obs, exp_vec());
            end
            if (r == 5) begin
                checks++;
                if ({ap_done, ap_ready} !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_full: got %b expected 10",
                             {ap_done, ap_ready});
                end
            end
            if (r == 6) begin
                checks++;
                if ({ap_done, op_start} !== 5'b00000 || job_cnt !== 32'd1) begin
                    errors++;
                    $display("FAIL b2b_retire: got %b cnt %0d expected 00000 1",
                             {ap_done, op_start}, job_cnt);
                end
            end
            if (r == 7) begin
                checks++;
                if (op_start !== 4'b0001) begin
                    errors++;
                    $display("FAIL b2b_redispatch: got %b expected 0001",
                             op_start);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int r = 0; r < 3; r++) cyc(1'b1, 1'b0, '0, '0);
        cyc(1'b0, 1'b0, 4'b0001, 4'b0001);
        cyc(1'b0, 1'b0, '0, '0);
        checks++;
        if (ap_done !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: ap_done %b expected 1", ap_done);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL midrst_async: got %h expected %h", obs, RST_VEC);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int r = 0; r < 6; r++) begin
            if (r == 0) cyc(1'b0, 1'b0, 4'b0111, 4'b0111);
            else cyc(1'b0, 1'b1, '0, '0);
            checks++;
            if ({ap_done, op_start} !== 5'b0 || obs !== exp_vec()) begin
                errors++;
                $display("FAIL midrst_after r%0d: got %h expected %h",
                         r, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] ec;
        logic [N-1:0] wd;
        do_reset();
        for (int r = 0; r < 600; r++) begin
            ec = N'($urandom & $urandom);
            wd = N'($urandom & $urandom);
            cyc(1'($urandom % 2), 1'(($urandom % 3) != 0), ec, wd);
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random r%0d: got %h expected %h",
                         r, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_fill();
        test_in_order();
        test_same_cycle_ignore();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
